// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the direct-mapped write-back
// data cache (dcache_dm_wb).
//   state_e       controller states
//   OFFSET_W      byte-offset bits inside a 32-byte block
//   WORDS_PER_BLK 32-bit words per block
//   BLK_W         block width on the memory side
//   byte_en()     store size + low address bits -> 4-bit lane mask
package dcache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_FL_SCAN,
    S_FL_WB
  } state_e;

  localparam int OFFSET_W      = 5;
  localparam int WORDS_PER_BLK = 8;
  localparam int BLK_W         = 256;

  // size 1/2/3 bytes, 0 means a full word. The mask is built in 8 bits and
  // shifted up by the byte offset; lanes pushed above 3 are dropped, so a
  // store never wraps into the next word.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    logic [7:0] m;
    case (size)
      2'd1:    m = 8'h01;
      2'd2:    m = 8'h03;
      2'd3:    m = 8'h07;
      default: m = 8'h0F;
    endcase
    m = m << lo;
    return m[3:0];
  endfunction

endpackage

// File: rtl/dcache_byte_merge.sv
// dcache_byte_merge: per-lane select between the stored word and the
// (already lane-aligned) store data.
//   old_word  current word from the line
//   new_word  store data shifted to its byte lanes
//   be        lane enables
//   merged    result written back to the line
module dcache_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign merged[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
  end

endmodule

// File: rtl/dcache_dm_wb.sv
// dcache_dm_wb: direct-mapped, write-back, write-allocate data cache between
// MEM and the 256-bit block memory port, with a SYS flush sequence.
// Optional macro DCACHE_PERF_CNT_EN adds hit/miss/writeback counters.
//   CLK, RESET                 clock, synchronous active-high reset
//   *_2DC / *_fDC              pipeline side: address, read/write, store data
//                              and size, load data, data_valid (0 = stall)
//   flush_2DC / flush_done     flush request level and completion
//   *_2DM / *_fDM, dBlkRead,
//   dBlkWrite                  block memory request/response handshake
//   hit_count, miss_count,
//   wb_count                   saturating counters (macro only)
module dcache_dm_wb
  import dcache_pkg::*;
#(
  parameter  int NUM_LINES = 32,
  localparam int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      data_address_2DC,
  input  logic             read_2DC,
  input  logic             write_2DC,
  input  logic [31:0]      data_write_2DC,
  input  logic [1:0]       data_write_size_2DC,
  output logic [31:0]      data_read_fDC,
  output logic             data_valid_fDC,
  input  logic             flush_2DC,
  output logic             flush_done,
  output logic [31:0]      data_address_2DM,
  input  logic [BLK_W-1:0] block_read_fDM,
  output logic [BLK_W-1:0] block_write_2DM,
  output logic             dBlkRead,
  output logic             dBlkWrite,
  input  logic             block_read_fDM_valid,
  input  logic             block_write_fDM_valid
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count,
  output logic [31:0]      wb_count
`endif
);

  localparam int TAG_W = 32 - IDX_W - OFFSET_W;

  // line storage; only valid/dirty are reset
  logic [NUM_LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [BLK_W-1:0]     data_q [NUM_LINES];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             rd_q, rd_d, wr_q, wr_d;
  logic [31:0]      addr_q, addr_d;
  logic [BLK_W-1:0] bw_q, bw_d;
  logic             flushed_q, flushed_d;   // scan finished for the current flush level
  logic             fdone_q, fdone_d;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [2:0]       req_word;
  logic             req, hit, ptr_last, fill_we, word_we, end_scan;
  logic [31:0]      cur_word, store_sh, merged_word;
  logic [3:0]       be;

  assign req_idx  = data_address_2DC[OFFSET_W +: IDX_W];
  assign req_tag  = data_address_2DC[31 -: TAG_W];
  assign req_word = data_address_2DC[4:2];
  assign req      = read_2DC | write_2DC;
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cur_word = data_q[req_idx][{req_word, 5'b0} +: 32];
  assign ptr_last = (ptr_q == IDX_W'(NUM_LINES - 1));
  assign be       = byte_en(data_write_size_2DC, data_address_2DC[1:0]);
  assign store_sh = data_write_2DC << {data_address_2DC[1:0], 3'b0};

  dcache_byte_merge u_merge (
    .old_word (cur_word),
    .new_word (store_sh),
    .be       (be),
    .merged   (merged_word)
  );

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    rd_d           = rd_q;
    wr_d           = wr_q;
    addr_d         = addr_q;
    bw_d           = bw_q;
    flushed_d      = flushed_q & flush_2DC;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    fill_we        = 1'b0;
    word_we        = 1'b0;
    end_scan       = 1'b0;
    data_valid_fDC = 1'b0;
    data_read_fDC  = '0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            data_valid_fDC = 1'b1;
            if (read_2DC) data_read_fDC = cur_word;
            if (write_2DC) begin
              word_we          = 1'b1;
              dirty_d[req_idx] = 1'b1;
            end
          end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d = S_WB;
            wr_d    = 1'b1;
            addr_d  = {tag_q[req_idx], req_idx, 5'b0};
            bw_d    = data_q[req_idx];
          end else begin
            state_d = S_FILL;
            rd_d    = 1'b1;
            addr_d  = {data_address_2DC[31:5], 5'b0};
          end
        end else begin
          data_valid_fDC = 1'b1;
          if (flush_2DC && !flushed_q) begin
            state_d = S_FL_SCAN;
            ptr_d   = '0;
          end
        end
      end
      S_WB: if (block_write_fDM_valid) begin
        wr_d             = 1'b0;
        dirty_d[req_idx] = 1'b0;
        state_d          = S_FILL;
        rd_d             = 1'b1;
        addr_d           = {data_address_2DC[31:5], 5'b0};
      end
      S_FILL: if (block_read_fDM_valid) begin
        fill_we          = 1'b1;
        valid_d[req_idx] = 1'b1;
        dirty_d[req_idx] = 1'b0;
        rd_d             = 1'b0;
        state_d          = S_IDLE;
      end
      S_FL_SCAN: begin
        if (valid_q[ptr_q] && dirty_q[ptr_q]) begin
          state_d = S_FL_WB;
          wr_d    = 1'b1;
          addr_d  = {tag_q[ptr_q], ptr_q, 5'b0};
          bw_d    = data_q[ptr_q];
        end else begin
          valid_d[ptr_q] = 1'b0;
          end_scan       = ptr_last;
          ptr_d          = ptr_q + IDX_W'(1);
        end
      end
      S_FL_WB: if (block_write_fDM_valid) begin
        wr_d           = 1'b0;
        valid_d[ptr_q] = 1'b0;
        dirty_d[ptr_q] = 1'b0;
        end_scan       = ptr_last;
        ptr_d          = ptr_q + IDX_W'(1);
        state_d        = S_FL_SCAN;
      end
      default: state_d = S_IDLE;
    endcase
    if (end_scan) begin
      state_d   = S_IDLE;
      flushed_d = flush_2DC;
    end
    // end_scan covers the cycle where the last valid line is being dropped
    fdone_d = flush_2DC && (end_scan || (valid_q == '0));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      bw_q      <= '0;
      flushed_q <= 1'b0;
      fdone_q   <= 1'b0;
      valid_q   <= '0;
      dirty_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      bw_q      <= bw_d;
      flushed_q <= flushed_d;
      fdone_q   <= fdone_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && fill_we) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= block_read_fDM;
    end else if (!RESET && word_we) begin
      data_q[req_idx][{req_word, 5'b0} +: 32] <= merged_word;
    end
  end

  assign dBlkRead         = rd_q;
  assign dBlkWrite        = wr_q;
  assign data_address_2DM = addr_q;
  assign block_write_2DM  = bw_q;
  assign flush_done       = fdone_q & flush_2DC;

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_q, hit_d, miss_q, miss_d, wbc_q, wbc_d;
  logic        missed_q, missed_d;   // current request already missed once
  logic        done_req, wb_acc;

  assign done_req = (state_q == S_IDLE) && req && hit;
  assign wb_acc   = wr_q && block_write_fDM_valid;

  always_comb begin
    missed_d = missed_q;
    if (done_req) missed_d = 1'b0;
    else if (state_q == S_IDLE && req) missed_d = 1'b1;
    hit_d  = (done_req && !missed_q && hit_q != '1) ? hit_q + 32'd1 : hit_q;
    miss_d = (done_req && missed_q && miss_q != '1) ? miss_q + 32'd1 : miss_q;
    wbc_d  = (wb_acc && wbc_q != '1) ? wbc_q + 32'd1 : wbc_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_q    <= '0;
      miss_q   <= '0;
      wbc_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      wbc_q    <= wbc_d;
      missed_q <= missed_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wbc_q;
`endif

endmodule

// File: tb/tb_dcache_dm_wb.sv
// tb_dcache_dm_wb: randomized self-checking bench for dcache_dm_wb.
// A flat byte-addressed reference memory gives the architectural value of
// every load; a tag/valid/dirty table per index predicts hits, misses and
// writebacks. A behavioural block memory answers dBlkRead/dBlkWrite.
module tb_dcache_dm_wb;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  data_address_2DC, data_write_2DC, data_read_fDC, data_address_2DM;
  logic         read_2DC, write_2DC, data_valid_fDC, flush_2DC, flush_done;
  logic [1:0]   data_write_size_2DC;
  logic [255:0] block_read_fDM, block_write_2DM;
  logic         dBlkRead, dBlkWrite, block_read_fDM_valid, block_write_fDM_valid;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_count, miss_count, wb_count;
`endif

  always #5 CLK = ~CLK;

  dcache_dm_wb #(.NUM_LINES(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .data_address_2DC(data_address_2DC), .read_2DC(read_2DC), .write_2DC(write_2DC),
    .data_write_2DC(data_write_2DC), .data_write_size_2DC(data_write_size_2DC),
    .data_read_fDC(data_read_fDC), .data_valid_fDC(data_valid_fDC),
    .flush_2DC(flush_2DC), .flush_done(flush_done),
    .data_address_2DM(data_address_2DM), .block_read_fDM(block_read_fDM),
    .block_write_2DM(block_write_2DM), .dBlkRead(dBlkRead), .dBlkWrite(dBlkWrite),
    .block_read_fDM_valid(block_read_fDM_valid), .block_write_fDM_valid(block_write_fDM_valid)
`ifdef DCACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- block memory ----------------
  logic [255:0] mem [logic [31:0]];
  int           cur_lat  = 2;
  int           wait_cnt = 0;
  int           ev_kind [$];        // 0 = block read, 1 = block write
  logic [31:0]  ev_addr [$];
  logic [255:0] ev_data [$];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h1000) return 32'hDEADBEEF;
    return a * 32'h9E3779B1 + 32'h01357ACE;
  endfunction

  function automatic logic [255:0] mem_get(input logic [31:0] blk);
    logic [255:0] b;
    if (mem.exists(blk)) return mem[blk];
    for (int w = 0; w < 8; w++) b[32*w +: 32] = init_word(blk + 32'(4*w));
    return b;
  endfunction

  initial begin : mem_rsp
    block_read_fDM_valid  = 1'b0;
    block_write_fDM_valid = 1'b0;
    block_read_fDM        = '0;
    forever begin
      @(negedge CLK);
      block_read_fDM_valid  = 1'b0;
      block_write_fDM_valid = 1'b0;
      if (RESET || !(dBlkRead || dBlkWrite)) wait_cnt = 0;
      else if (wait_cnt < cur_lat) wait_cnt++;
      else begin
        wait_cnt = 0;
        if (dBlkWrite) begin
          mem[data_address_2DM] = block_write_2DM;
          ev_kind.push_back(1); ev_addr.push_back(data_address_2DM); ev_data.push_back(block_write_2DM);
          block_write_fDM_valid = 1'b1;
        end else begin
          block_read_fDM = mem_get(data_address_2DM);
          ev_kind.push_back(0); ev_addr.push_back(data_address_2DM); ev_data.push_back('0);
          block_read_fDM_valid = 1'b1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  refmem [logic [31:0]];
  bit          m_v [32];
  bit          m_d [32];
  logic [21:0] m_tag [32];
  int          exp_hit = 0, exp_miss = 0, exp_wb = 0;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] a2, iw, r;
    a2 = {a[31:2], 2'b00};
    iw = init_word(a2);
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = refmem.exists(a2 + 32'(k)) ? refmem[a2 + 32'(k)] : iw[8*k +: 8];
    return r;
  endfunction

  function automatic logic [255:0] ref_block(input logic [31:0] blk);
    logic [255:0] b;
    for (int w = 0; w < 8; w++) b[32*w +: 32] = ref_word(blk + 32'(4*w));
    return b;
  endfunction

  function automatic void model_invalidate();
    for (int i = 0; i < 32; i++) begin m_v[i] = 0; m_d[i] = 0; end
  endfunction

  function automatic void model_access(input logic [31:0] a, input bit wr, input logic [31:0] d,
                                       input logic [1:0] sz, output bit hit, output bit wb,
                                       output logic [31:0] wb_addr);
    int ix, n, lane;
    ix      = int'(a[9:5]);
    hit     = m_v[ix] && (m_tag[ix] == a[31:10]);
    wb      = !hit && m_v[ix] && m_d[ix];
    wb_addr = {m_tag[ix], a[9:5], 5'b0};
    if (hit) exp_hit++; else exp_miss++;
    if (wb) exp_wb++;
    if (!hit) begin m_v[ix] = 1; m_d[ix] = 0; m_tag[ix] = a[31:10]; end
    if (wr) begin
      m_d[ix] = 1;
      n = (sz == 2'd0) ? 4 : int'(sz);
      for (int i = 0; i < n; i++) begin
        lane = int'(a[1:0]) + i;
        if (lane < 4) refmem[{a[31:2], 2'b00} + 32'(lane)] = d[8*i +: 8];
      end
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                        output logic [31:0] rd, output int cyc);
    @(negedge CLK);
    read_2DC = !wr; write_2DC = wr; data_address_2DC = a; data_write_2DC = d; data_write_size_2DC = sz;
    cyc = 0;
    #1;
    while (!data_valid_fDC && cyc <= 300) begin @(negedge CLK); #1; cyc++; end
    n_vec++;
    if (!data_valid_fDC) begin
      n_bad++;
      $display("FAIL req_timeout addr=%h got data_valid=0 want 1 within 300 cycles", a);
    end
    rd = data_read_fDC;
    @(posedge CLK); #1;
    read_2DC = 1'b0; write_2DC = 1'b0;
  endtask

  task automatic run_flush(output bit done);
    int c = 0;
    @(negedge CLK); flush_2DC = 1'b1; #1;
    while (!flush_done && c <= 500) begin @(negedge CLK); #1; c++; end
    done = flush_done;
    @(negedge CLK); flush_2DC = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b1; read_2DC = 0; write_2DC = 0; flush_2DC = 0;
    data_address_2DC = '0; data_write_2DC = '0; data_write_size_2DC = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0; #1;
    model_invalidate();
    n_vec += 7;
    if (dBlkRead !== 1'b0) begin n_bad++; $display("FAIL rst_dBlkRead got %b want 0", dBlkRead); end
    if (dBlkWrite !== 1'b0) begin n_bad++; $display("FAIL rst_dBlkWrite got %b want 0", dBlkWrite); end
    if (data_address_2DM !== 32'h0) begin n_bad++; $display("FAIL rst_addr_2DM got %h want 0", data_address_2DM); end
    if (block_write_2DM !== 256'h0) begin n_bad++; $display("FAIL rst_block_write got %h want 0", block_write_2DM); end
    if (flush_done !== 1'b0) begin n_bad++; $display("FAIL rst_flush_done got %b want 0", flush_done); end
    if (data_read_fDC !== 32'h0) begin n_bad++; $display("FAIL rst_data_read got %h want 0", data_read_fDC); end
    if (data_valid_fDC !== 1'b1) begin n_bad++; $display("FAIL rst_data_valid got %b want 1", data_valid_fDC); end
  endtask

  task automatic test_cold_read();
    bit h, wb; logic [31:0] wa; int c = 0; int ne = ev_kind.size();
    cur_lat = 3;
    model_access(32'h1000, 0, '0, '0, h, wb, wa);
    @(negedge CLK); read_2DC = 1; data_address_2DC = 32'h1000; #1;
    n_vec++;
    if (data_valid_fDC !== 1'b0) begin n_bad++; $display("FAIL cold_stall got valid=%b want 0", data_valid_fDC); end
    @(negedge CLK); #1;
    n_vec++;
    if (dBlkRead !== 1'b1 || data_address_2DM !== 32'h1000) begin
      n_bad++; $display("FAIL cold_blkread got rd=%b addr=%h want rd=1 addr=00001000", dBlkRead, data_address_2DM);
    end
    while (!data_valid_fDC && c < 100) begin @(negedge CLK); #1; c++; end
    n_vec++;
    if (data_valid_fDC !== 1'b1 || data_read_fDC !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL cold_data got valid=%b data=%h want 1 deadbeef", data_valid_fDC, data_read_fDC);
    end
    @(posedge CLK); #1; read_2DC = 0;
    n_vec++;
    if (ev_kind.size() != ne + 1 || ev_kind[ne] != 0) begin
      n_bad++; $display("FAIL cold_traffic got %0d events want 1 block read", ev_kind.size() - ne);
    end
    cur_lat = 2;
  endtask

  task automatic test_write_byte();
    bit h, wb; logic [31:0] wa, rd; int cyc; int ne = ev_kind.size();
    model_access(32'h1000, 1, 32'h000000AB, 2'd1, h, wb, wa);
    do_req(1, 32'h1000, 32'h000000AB, 2'd1, rd, cyc);
    n_vec++;
    if (cyc != 0) begin n_bad++; $display("FAIL wbyte_hit_lat got %0d want 0", cyc); end
    do_req(0, 32'h1000, '0, '0, rd, cyc);
    n_vec += 2;
    if (rd !== 32'hDEADBEAB || rd !== ref_word(32'h1000)) begin n_bad++; $display("FAIL wbyte_data got %h want deadbeab", rd); end
    if (ev_kind.size() != ne) begin n_bad++; $display("FAIL wbyte_traffic got %0d events want 0", ev_kind.size() - ne); end
  endtask

  task automatic test_write_size3();
    bit h, wb; logic [31:0] wa, rd; int cyc;
    model_access(32'h1002, 1, 32'h00CCBBAA, 2'd3, h, wb, wa);
    do_req(1, 32'h1002, 32'h00CCBBAA, 2'd3, rd, cyc);
    do_req(0, 32'h1000, '0, '0, rd, cyc);
    n_vec++;
    if (rd !== 32'hBBAABEAB || cyc != 0) begin n_bad++; $display("FAIL wsize3 got %h lat %0d want bbaabeab lat 0", rd, cyc); end
  endtask

  task automatic test_evict();
    bit h, wb; logic [31:0] wa, rd; logic [255:0] eb; int cyc; int ne = ev_kind.size();
    eb = ref_block(32'h1000);
    model_access(32'h1400, 0, '0, '0, h, wb, wa);
    do_req(0, 32'h1400, '0, '0, rd, cyc);
    n_vec += 3;
    if (ev_kind.size() != ne + 2) begin
      n_bad++; $display("FAIL evict_count got %0d events want 2", ev_kind.size() - ne);
    end else begin
      if (ev_kind[ne] != 1 || ev_addr[ne] !== 32'h1000 || ev_data[ne] !== eb) begin
        n_bad++; $display("FAIL evict_wb got kind %0d addr %h want write 00001000 data %h", ev_kind[ne], ev_addr[ne], eb);
      end
      if (ev_kind[ne+1] != 0 || ev_addr[ne+1] !== 32'h1400) begin
        n_bad++; $display("FAIL evict_fill got kind %0d addr %h want read 00001400", ev_kind[ne+1], ev_addr[ne+1]);
      end
    end
    if (rd !== ref_word(32'h1400)) begin n_bad++; $display("FAIL evict_data got %h want %h", rd, ref_word(32'h1400)); end
  endtask

  task automatic test_random();
    bit h, wb, wr; logic [31:0] a, d, wa, rd; logic [1:0] sz; logic [255:0] eb; int cyc, ne, nw;
    for (int it = 0; it < 300; it++) begin
      cur_lat = $urandom_range(0, 3);
      wr = $urandom_range(0, 1);
      a  = {22'(4 + $urandom_range(0, 2)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      if (wr) a[1:0] = 2'($urandom_range(0, 3));
      d  = $urandom; sz = 2'($urandom_range(0, 3));
      ne = ev_kind.size();
      model_access(a, wr, d, sz, h, wb, wa);
      eb = ref_block(wa);
      do_req(wr, a, d, sz, rd, cyc);
      n_vec += 2;
      if (h ? (cyc != 0) : (cyc < 2)) begin n_bad++; $display("FAIL rnd_latency addr=%h got %0d cycles want hit=%b", a, cyc, h); end
      nw = 0;
      for (int i = ne; i < ev_kind.size(); i++) if (ev_kind[i] == 1) nw++;
      if (nw != (wb ? 1 : 0)) begin
        n_bad++; $display("FAIL rnd_wb_count addr=%h got %0d want %0d", a, nw, wb ? 1 : 0);
      end else if (wb) begin
        n_vec++;
        if (ev_addr[ne] !== wa || ev_data[ne] !== eb) begin
          n_bad++; $display("FAIL rnd_wb_block got addr %h want %h", ev_addr[ne], wa);
        end
      end
      if (!wr) begin
        n_vec++;
        if (rd !== ref_word(a)) begin n_bad++; $display("FAIL rnd_read addr=%h got %h want %h", a, rd, ref_word(a)); end
      end
    end
    cur_lat = 2;
`ifdef DCACHE_PERF_CNT_EN
    n_vec++;
    if (hit_count !== 32'(exp_hit) || miss_count !== 32'(exp_miss) || wb_count !== 32'(exp_wb)) begin
      n_bad++; $display("FAIL perf_counts got %0d/%0d/%0d want %0d/%0d/%0d", hit_count, miss_count, wb_count, exp_hit, exp_miss, exp_wb);
    end
`endif
  endtask

  task automatic test_flush();
    bit h, wb, ok; logic [31:0] wa, rd; int cyc, ne, c;
    logic [31:0] xa [$]; logic [255:0] xd [$];
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        model_access(32'h2000, 1, 32'h11223344, 2'd0, h, wb, wa); do_req(1, 32'h2000, 32'h11223344, 2'd0, rd, cyc);
        model_access(32'h2024, 1, 32'h00005566, 2'd2, h, wb, wa); do_req(1, 32'h2024, 32'h00005566, 2'd2, rd, cyc);
        model_access(32'h2048, 0, '0, '0, h, wb, wa);             do_req(0, 32'h2048, '0, '0, rd, cyc);
      end
      xa.delete(); xd.delete();
      for (int i = 0; i < 32; i++)
        if (m_v[i] && m_d[i]) begin xa.push_back({m_tag[i], 5'(i), 5'b0}); xd.push_back(ref_block({m_tag[i], 5'(i), 5'b0})); end
      exp_wb += xa.size();
      ne = ev_kind.size();
      run_flush(ok);
      model_invalidate();
      n_vec += 2;
      if (!ok) begin n_bad++; $display("FAIL flush_done_ph%0d got 0 want 1 within 500 cycles", ph); end
      if (ev_kind.size() - ne != xa.size()) begin
        n_bad++; $display("FAIL flush_wb_count_ph%0d got %0d want %0d", ph, ev_kind.size() - ne, xa.size());
      end else begin
        for (int i = 0; i < xa.size(); i++) begin
          n_vec++;
          if (ev_kind[ne+i] != 1 || ev_addr[ne+i] !== xa[i] || ev_data[ne+i] !== xd[i]) begin
            n_bad++; $display("FAIL flush_wb_ph%0d got addr %h want %h", ph, ev_addr[ne+i], xa[i]);
          end
        end
      end
      if (ph == 1) begin
        n_vec++;
        if (xa.size() != 2) begin n_bad++; $display("FAIL flush_two_dirty got %0d want 2", xa.size()); end
      end
    end
    // already flushed: done on the cycle after entry
    @(negedge CLK); flush_2DC = 1'b1;
    @(negedge CLK); #1;
    n_vec++;
    if (flush_done !== 1'b1) begin n_bad++; $display("FAIL flush_again got %b want 1", flush_done); end
    @(negedge CLK); flush_2DC = 1'b0;
    c = 0;
    model_access(32'h2048, 0, '0, '0, h, wb, wa);
    do_req(0, 32'h2048, '0, '0, rd, cyc);
    n_vec += 2;
    if (cyc < 2) begin n_bad++; $display("FAIL flush_clean_miss got %0d cycles want >=2", cyc); end
    if (rd !== ref_word(32'h2048)) begin n_bad++; $display("FAIL flush_clean_data got %h want %h", rd, ref_word(32'h2048)); end
  endtask

  task automatic test_reset_fill();
    bit h, wb; logic [31:0] wa, rd; int cyc, ne;
    cur_lat = 40;
    @(negedge CLK); read_2DC = 1; data_address_2DC = 32'h3000;
    repeat (3) @(negedge CLK);
    #1;
    n_vec++;
    if (dBlkRead !== 1'b1) begin n_bad++; $display("FAIL rstfill_in_fill got rd=%b want 1", dBlkRead); end
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0; read_2DC = 0; #1;
    model_invalidate();
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
    n_vec++;
    if (dBlkRead !== 1'b0 || dBlkWrite !== 1'b0) begin
      n_bad++; $display("FAIL rstfill_drop got rd=%b wr=%b want 0 0", dBlkRead, dBlkWrite);
    end
`ifdef DCACHE_PERF_CNT_EN
    n_vec++;
    if (hit_count !== 0 || miss_count !== 0 || wb_count !== 0) begin
      n_bad++; $display("FAIL rstfill_perf got %0d/%0d/%0d want 0/0/0", hit_count, miss_count, wb_count);
    end
`endif
    cur_lat = 2;
    ne = ev_kind.size();
    model_access(32'h2048, 0, '0, '0, h, wb, wa);
    do_req(0, 32'h2048, '0, '0, rd, cyc);
    n_vec += 2;
    if (cyc < 2 || h) begin n_bad++; $display("FAIL rstfill_invalid got %0d cycles want miss", cyc); end
    if (rd !== ref_word(32'h2048)) begin n_bad++; $display("FAIL rstfill_data got %h want %h", rd, ref_word(32'h2048)); end
    n_vec++;
    for (int i = ne; i < ev_kind.size(); i++)
      if (ev_kind[i] == 1) begin n_bad++; $display("FAIL rstfill_no_wb got block write at %h want none", ev_addr[i]); break; end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_read();
    test_write_byte();
    test_write_size3();
    test_evict();
    test_random();
    test_flush();
    test_reset_fill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
